// File: rtl/clock_pattern_checker_pkg.sv
// Shared definitions for the mainband clock-training pattern checker.
// The transmit clock generator uses the same constants, so both ends of the
// link agree on the shape of the training pattern.
//   state_t           : checker FSM states
//   OSR               : oversampling-clock cycles per forwarded-clock period
//   PULSES_PER_BURST  : rising edges expected per burst on each pin
//   ITERATIONS        : bursts evaluated per training run
//   IDLE_CYCLES       : CKP-quiet sample cycles that close a burst
//   TIMEOUT_CYCLES    : no-edge abort limit (timeout build only)
//   sat_inc8          : saturating 8-bit increment for the error counters
package clock_pattern_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BURST,
        IN_BURST,
        EVAL,
        DONE
    } state_t;

    localparam int unsigned OSR              = 4;
    localparam int unsigned PULSES_PER_BURST = 16;
    localparam int unsigned ITERATIONS       = 128;
    localparam int unsigned IDLE_CYCLES      = 8;
    localparam int unsigned TIMEOUT_CYCLES   = 4096;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == '1) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/clock_pattern_checker_clk_edge_sync.sv
// clk_edge_sync: brings one forwarded-clock pin into the sample-clock domain
// through a 2-flop synchronizer, keeps one history flop and flags rising edges.
//   clk   : oversampling clock
//   rst_n : asynchronous active-low reset
//   din   : raw pin, asynchronous to clk
//   rise  : one-cycle pulse, s2 & ~s3
module clk_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/clock_pattern_checker.sv
// clock_pattern_checker: receive-side checker for mainband clock training.
// Counts rising edges of CKP, CKN and TRACK in each burst of the gated
// training pattern and reports per-pin bad-burst counts, pass and done.
// Optional feature macro: CLK_PATTERN_CHECKER_TIMEOUT_EN adds a no-edge
// timeout that aborts the run; without it o_timeout is tied low.
//   i_sample_clk              : oversampling clock, all logic runs on it
//   i_rst_n                   : asynchronous active-low reset
//   i_start                   : start pulse, honoured only in IDLE or DONE
//   i_CKP, i_CKN, i_TRACK     : received forwarded-clock pins
//   o_busy                    : run in progress
//   o_done                    : run finished, held until the next start
//   o_pass                    : all bursts clean, valid while o_done
//   o_ckp_err/o_ckn_err/o_track_err : saturating bad-burst counts
//   o_iter_cnt                : bursts evaluated so far
//   o_timeout                 : run aborted on timeout
module clock_pattern_checker
    import clock_pattern_checker_pkg::*;
#(
    parameter int unsigned OSR              = clock_pattern_checker_pkg::OSR,
    parameter int unsigned PULSES_PER_BURST = clock_pattern_checker_pkg::PULSES_PER_BURST,
    parameter int unsigned ITERATIONS       = clock_pattern_checker_pkg::ITERATIONS,
    parameter int unsigned IDLE_CYCLES      = clock_pattern_checker_pkg::IDLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = clock_pattern_checker_pkg::TIMEOUT_CYCLES
) (
    input  logic                              i_sample_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic                              i_CKP,
    input  logic                              i_CKN,
    input  logic                              i_TRACK,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_pass,
    output logic [7:0]                        o_ckp_err,
    output logic [7:0]                        o_ckn_err,
    output logic [7:0]                        o_track_err,
    output logic [$clog2(ITERATIONS+1)-1:0]   o_iter_cnt,
    output logic                              o_timeout
);

    localparam int unsigned IW  = $clog2(ITERATIONS + 1);
    localparam int unsigned IDW = $clog2(IDLE_CYCLES + 1);

    // The idle window must exceed one clock period so gaps inside a burst
    // never close it, yet stay below the 8-period inter-burst gap.
    if (OSR < 4 || IDLE_CYCLES <= OSR || IDLE_CYCLES >= 8 * OSR ||
        PULSES_PER_BURST >= 31 || ITERATIONS < 1 ||
        TIMEOUT_CYCLES <= IDLE_CYCLES) begin : g_bad_params
        $error("clock_pattern_checker: parameter out of range");
    end

    logic ckp_rise;
    logic ckn_rise;
    logic track_rise;

    clk_edge_sync u_ckp_sync (
        .clk   (i_sample_clk),
        .rst_n (i_rst_n),
        .din   (i_CKP),
        .rise  (ckp_rise)
    );

    clk_edge_sync u_ckn_sync (
        .clk   (i_sample_clk),
        .rst_n (i_rst_n),
        .din   (i_CKN),
        .rise  (ckn_rise)
    );

    clk_edge_sync u_track_sync (
        .clk   (i_sample_clk),
        .rst_n (i_rst_n),
        .din   (i_TRACK),
        .rise  (track_rise)
    );

    state_t         state;
    state_t         state_nxt;
    logic [4:0]     ckp_cnt;
    logic [4:0]     ckn_cnt;
    logic [4:0]     track_cnt;
    logic [IDW-1:0] idle_cnt;
    logic           count_en;
    logic           start_ok;
    logic           burst_end;
    logic           last_iter;
    logic           timeout_hit;
    logic [7:0]     ckp_err_nxt;
    logic [7:0]     ckn_err_nxt;
    logic [7:0]     track_err_nxt;

    // CKN/TRACK edges seen in WAIT_BURST belong to the coming burst, so a
    // pin skewed ahead of CKP is not split across two bursts.
    assign count_en  = (state == WAIT_BURST) || (state == IN_BURST);
    assign start_ok  = i_start && ((state == IDLE) || (state == DONE));
    assign burst_end = (state == IN_BURST) && (idle_cnt == IDW'(IDLE_CYCLES));
    assign last_iter = (32'(o_iter_cnt) + 32'd1) >= ITERATIONS;
    assign o_busy    = (state == WAIT_BURST) || (state == IN_BURST) || (state == EVAL);

    assign ckp_err_nxt   = (ckp_cnt   != 5'(PULSES_PER_BURST)) ? sat_inc8(o_ckp_err)   : o_ckp_err;
    assign ckn_err_nxt   = (ckn_cnt   != 5'(PULSES_PER_BURST)) ? sat_inc8(o_ckn_err)   : o_ckn_err;
    assign track_err_nxt = (track_cnt != 5'(PULSES_PER_BURST)) ? sat_inc8(o_track_err) : o_track_err;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (i_start) state_nxt = WAIT_BURST;
            end
            WAIT_BURST: begin
                if (timeout_hit)   state_nxt = DONE;
                else if (ckp_rise) state_nxt = IN_BURST;
            end
            IN_BURST: begin
                if (timeout_hit)    state_nxt = DONE;
                else if (burst_end) state_nxt = EVAL;
            end
            EVAL: begin
                state_nxt = last_iter ? DONE : WAIT_BURST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ckp_cnt   <= '0;
            ckn_cnt   <= '0;
            track_cnt <= '0;
        end else if (start_ok || (state == EVAL)) begin
            ckp_cnt   <= '0;
            ckn_cnt   <= '0;
            track_cnt <= '0;
        end else if (count_en) begin
            if (ckp_rise   && (ckp_cnt   != '1)) ckp_cnt   <= ckp_cnt   + 5'd1;
            if (ckn_rise   && (ckn_cnt   != '1)) ckn_cnt   <= ckn_cnt   + 5'd1;
            if (track_rise && (track_cnt != '1)) track_cnt <= track_cnt + 5'd1;
        end
    end

    // Idle window restarts on every CKP edge; it runs only inside a burst.
    always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (state != IN_BURST || ckp_rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDW'(IDLE_CYCLES)) begin
            idle_cnt <= idle_cnt + IDW'(1);
        end
    end

    always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ckp_err   <= '0;
            o_ckn_err   <= '0;
            o_track_err <= '0;
            o_iter_cnt  <= '0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                o_ckp_err   <= '0;
                o_ckn_err   <= '0;
                o_track_err <= '0;
                o_iter_cnt  <= '0;
                o_done      <= 1'b0;
                o_pass      <= 1'b0;
            end else if (state == EVAL) begin
                o_ckp_err   <= ckp_err_nxt;
                o_ckn_err   <= ckn_err_nxt;
                o_track_err <= track_err_nxt;
                o_iter_cnt  <= o_iter_cnt + IW'(1);
                if (last_iter) begin
                    o_done <= 1'b1;
                    o_pass <= (ckp_err_nxt == '0) && (ckn_err_nxt == '0) &&
                              (track_err_nxt == '0) &&
                              ((32'(o_iter_cnt) + 32'd1) == ITERATIONS);
                end
            end else if (timeout_hit) begin
                o_done <= 1'b1;
                o_pass <= 1'b0;
            end
        end
    end

`ifdef CLK_PATTERN_CHECKER_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] noedge_cnt;
    logic           timeout_q;

    assign timeout_hit = count_en && (noedge_cnt == TOW'(TIMEOUT_CYCLES));
    assign o_timeout   = timeout_q;

    always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            noedge_cnt <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (!count_en || ckp_rise || ckn_rise || track_rise) begin
                noedge_cnt <= '0;
            end else if (!timeout_hit) begin
                noedge_cnt <= noedge_cnt + TOW'(1);
            end
            if (start_ok) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_clock_pattern_checker.sv
// Directed bench for clock_pattern_checker: drives the gated training
// pattern (16 pulses at OSR=4, 8 idle periods) with planted defects and
// checks the run results against hand-computed values.
module tb_clock_pattern_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ckp   = 1'b0;
    logic       ckn   = 1'b0;
    logic       track = 1'b0;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] ckp_err;
    logic [7:0] ckn_err;
    logic [7:0] track_err;
    logic [7:0] iter_cnt;

    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   last_rise = 0;
    int   done_cyc  = 0;
    logic done_q    = 1'b0;

    clock_pattern_checker #(
        .OSR              (4),
        .PULSES_PER_BURST (16),
        .ITERATIONS       (128),
        .IDLE_CYCLES      (8),
        .TIMEOUT_CYCLES   (4096)
    ) dut (
        .i_sample_clk (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_CKP        (ckp),
        .i_CKN        (ckn),
        .i_TRACK      (track),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_ckp_err    (ckp_err),
        .o_ckn_err    (ckn_err),
        .o_track_err  (track_err),
        .o_iter_cnt   (iter_cnt),
        .o_timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle in which o_done first rises.
    always @(negedge clk) begin
        if (done && !done_q) done_cyc = cyc;
        done_q = done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One forwarded-clock period: CKP/TRACK high in the first half,
    // CKN high in the second half.
    task automatic drive_pulse(input bit p_on, input bit n_on, input bit t_on);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            ckp   = p_on && (s < 2);
            ckn   = n_on && (s >= 2);
            track = t_on && (s < 2);
            if (s == 0 && p_on) last_rise = cyc;
        end
    endtask

    task automatic drive_gap(input bit stray_start);
        for (int g = 0; g < 32; g++) begin
            @(negedge clk);
            ckp   = 1'b0;
            ckn   = 1'b0;
            track = 1'b0;
            start = stray_start && (g == 0);
        end
        start = 1'b0;
    endtask

    // mode 0: clean (stray start at burst 50), 1: CKN pulse 3 of burst 5 dropped,
    // 2: burst 10 has 17 pulses, 3: TRACK stuck low
    task automatic drive_run(input int mode, input int nbursts);
        for (int b = 0; b < nbursts; b++) begin
            int np;
            np = (mode == 2 && b == 10) ? 17 : 16;
            for (int p = 0; p < np; p++) begin
                drive_pulse(1'b1, !(mode == 1 && b == 5 && p == 2), mode != 3);
            end
            drive_gap(mode == 0 && b == 50);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_done_clr", done, 1'b0);
        check("start_pass_clr", pass, 1'b0);
        check("start_ckn_err_clr", ckn_err, 8'd0);
        check("start_track_err_clr", track_err, 8'd0);
        check("start_iter_clr", iter_cnt, 8'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_within_bound", done, 1'b1);
    endtask

    task automatic check_results(input string tag, input bit e_pass, input int e_ckp,
                                 input int e_ckn, input int e_track, input int e_iter);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_pass"}, pass, e_pass);
        check({tag, "_ckp_err"}, ckp_err, e_ckp);
        check({tag, "_ckn_err"}, ckn_err, e_ckn);
        check({tag, "_track_err"}, track_err, e_track);
        check({tag, "_iter"}, iter_cnt, e_iter);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_ckp_err"}, ckp_err, 8'd0);
        check({tag, "_ckn_err"}, ckn_err, 8'd0);
        check({tag, "_track_err"}, track_err, 8'd0);
        check({tag, "_iter"}, iter_cnt, 8'd0);
        check({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        start_run();
        drive_run(0, 128);
        wait_done(200);
        check_results("clean", 1'b1, 0, 0, 0, 128);
        check("clean_done_latency", done_cyc - last_rise, 13);

        start_run();
        drive_run(1, 128);
        wait_done(200);
        check_results("ckn_drop", 1'b0, 0, 1, 0, 128);

        start_run();
        drive_run(2, 128);
        wait_done(200);
        check_results("long_burst", 1'b0, 1, 1, 1, 128);

        start_run();
        drive_run(3, 128);
        wait_done(200);
        check_results("track_stuck", 1'b0, 0, 0, 128, 128);

        start_run();
        drive_run(0, 60);
        check("pre_reset_iter", iter_cnt, 8'd60);
        check("pre_reset_busy", busy, 1'b1);
        for (int p = 0; p < 5; p++) drive_pulse(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ckp   = 1'b0;
        ckn   = 1'b0;
        track = 1'b0;
        repeat (40) @(negedge clk);
        start_run();
        drive_run(0, 128);
        wait_done(200);
        check_results("post_reset", 1'b1, 0, 0, 0, 128);

`ifdef CLK_PATTERN_CHECKER_TIMEOUT_EN
        start_run();
        drive_run(0, 40);
        wait_done(5000);
        check("to_timeout", timeout, 1'b1);
        check("to_iter", iter_cnt, 8'd40);
        check("to_pass", pass, 1'b0);
        check("to_busy", busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_pattern_checker.md
# clock_pattern_checker

Receive-side checker for mainband clock training. It samples the forwarded CKP, CKN and TRACK pins with a local oversampling clock and counts rising edges in each burst of the gated training pattern: 16 clock pulses, then 8 idle periods, repeated. It reports per-signal burst errors, a pass flag and a done flag to the receiver training FSM. It is the far-end partner of the transmit clock generator's training mode.

## Interface
- OSR, 4: oversampling-clock cycles per forwarded-clock period; the value must be ≥ 4.
- PULSES_PER_BURST, 16: expected rising edges per burst on each pin.
- ITERATIONS, 128: number of bursts evaluated per training run.
- IDLE_CYCLES, 8: consecutive sample cycles with no CKP edge that close a burst; the value must lie in (OSR, 8*OSR).
- TIMEOUT_CYCLES, 4096: no-edge limit used only when the timeout feature is compiled in.
- i_sample_clk  in  1  oversampling clock. All logic runs on this clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle start pulse. Sampled only in IDLE or DONE.
- i_CKP, i_CKN, i_TRACK  in  1 each  received forwarded-clock pins; asynchronous to i_sample_clk.
- o_busy  out  1  high while a run is in progress.
- o_done  out  1  level; high from the end of a run until the next accepted i_start.
- o_pass  out  1  valid while o_done is high.
- o_ckp_err, o_ckn_err, o_track_err  out  8 each  per-pin count of bad bursts; saturate at 255.
- o_iter_cnt  out  $clog2(ITERATIONS+1)  number of bursts evaluated so far.
- o_timeout  out  1  high if the run aborted on timeout.

## Operation
- Input conditioning: each pin passes through a 2-flop synchronizer plus one history flop. A rising edge is s2 & ~s3.
- Edge counters: one 5-bit counter per pin, saturating at 31. Counting is enabled only in WAIT_BURST and IN_BURST.
- States:
  - IDLE: the run has not started.
  - WAIT_BURST: waiting for the first CKP edge of a burst.
  - IN_BURST: counting edges.
  - EVAL: one cycle that judges the burst.
  - DONE: results are held.
- Transitions:
  - IDLE/DONE → WAIT_BURST on i_start. This clears the edge counters, error counters, iteration count, o_done, o_pass and o_timeout.
  - WAIT_BURST → IN_BURST on a CKP edge; that edge is counted.
  - IN_BURST → EVAL when the idle counter reaches IDLE_CYCLES. The idle counter resets on every CKP edge.
  - EVAL → WAIT_BURST if o_iter_cnt+1 < ITERATIONS; otherwise EVAL → DONE.
- EVAL actions:
  - Each pin's counter is compared with PULSES_PER_BURST. A mismatch increments that pin's error counter.
  - o_iter_cnt increments.
  - Edge counters clear.
- CKN and TRACK edges that arrive while waiting for the first CKP edge are counted into the same burst. This keeps a skewed pin from being split across two bursts.
- o_pass = 1 when all three error counts are 0, o_iter_cnt == ITERATIONS and o_timeout = 0.
- A start pulse in WAIT_BURST, IN_BURST or EVAL is ignored.
- Reset value of every output is 0.
- Reset mid-run returns the block to IDLE immediately and clears all outputs.

## Timing
- Edge-detect latency: 3 i_sample_clk cycles from the pin rising to the counter update.
- o_done, o_pass and the final error counts update in the cycle after the last EVAL.
- From the last CKP rise to o_done: 3 + IDLE_CYCLES + 2 cycles.
- o_busy rises in the cycle after i_start and falls in the same cycle that o_done rises.
- The error counters and o_iter_cnt are registered. Their values change only in the cycle after EVAL.

## Configuration
- CLK_PATTERN_CHECKER_TIMEOUT_EN defined:
  - A no-edge counter runs in WAIT_BURST and IN_BURST.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with o_timeout=1 and o_pass=0.
  - Bursts already counted keep their evaluation.
- Undefined:
  - The checker waits for edges indefinitely.
  - o_timeout is tied to 0 and the no-edge counter is not instantiated.

## Structure
- The shared package holds:
  - the state enum (IDLE, WAIT_BURST, IN_BURST, EVAL, DONE);
  - the default constants OSR, PULSES_PER_BURST, ITERATIONS and IDLE_CYCLES, shared with the transmit clock generator.
- One sub-module, clk_edge_sync: a 2-flop synchronizer plus rising-edge detect. It is instantiated three times.

## Test plan
- Clean pattern, 128 bursts of 16 pulses with 8-period gaps at OSR=4 → o_done=1, o_pass=1, all error counts 0, o_iter_cnt=128.
- CKN pulse 3 of burst 5 suppressed → o_ckn_err=1, o_ckp_err=0, o_pass=0, o_iter_cnt=128.
- Burst 10 carries 17 pulses on all pins → every error count = 1.
- TRACK stuck low for the whole run → o_track_err=128, the others 0.
- Timeout build, pins held low after 40 bursts → o_timeout=1, o_iter_cnt=40, o_pass=0.
- i_rst_n pulsed during burst 60, then i_start → all outputs 0 after reset, and the following clean run passes.
